stopwatch_timer: RTL and testbench

//   Run/pause stopwatch: counts elapsed time as six packed BCD digits MM:SS:CC (centiseconds).

---
 rtl/stopwatch_timer.sv | 89 ++++++++
 tb/tb_stopwatch_timer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/stopwatch_timer.sv
// rtl/stopwatch_timer.sv - run/pause stopwatch counting MM:SS:CC as packed BCD
// A toggle rise flips run; a prescaler divides clk into centisecond ticks.
module stopwatch_timer #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        toggle,
  output logic [23:0] disp_time
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          tog_s1_q, tog_s2_q, tog_prev_q;
  logic          run_q, run_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [23:0]   time_q, time_d;
  logic          rise;
  logic          tick;

  assign rise = tog_s2_q & ~tog_prev_q;
  // Tick is gated by the run value before any flip on this edge.
  assign tick = run_q && (pre_q == PRE_LAST);

  always_comb begin
    run_d = run_q;
    if (rise) begin
      run_d = ~run_q;
    end
  end

  always_comb begin
    pre_d = pre_q;
    if (run_q) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Digit order from LSB: C1, C10, S1, S10, M1, M10; all carries settle in one edge.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    logic [3:0] lim;
    time_d = time_q;
    carry  = 1'b1;
    dig    = '0;
    lim    = '0;
    for (int i = 0; i < 6; i++) begin
      dig = time_q[i*4 +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (dig >= lim) begin
          time_d[i*4 +: 4] = 4'd0;
        end else begin
          time_d[i*4 +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tog_s1_q   <= 1'b0;
      tog_s2_q   <= 1'b0;
      tog_prev_q <= 1'b0;
      run_q      <= 1'b0;
      pre_q      <= '0;
      time_q     <= '0;
    end else begin
      tog_s1_q   <= toggle;
      tog_s2_q   <= tog_s1_q;
      tog_prev_q <= tog_s2_q;
      run_q      <= run_d;
      pre_q      <= pre_d;
      if (tick) begin
        time_q <= time_d;
      end
    end
  end

  assign disp_time = time_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb/tb_stopwatch_timer.sv - directed self-checking bench for stopwatch_timer
module tb_stopwatch_timer;

  logic        clk;
  logic        reset;
  logic        toggle;
  logic [23:0] disp_time;

  int n_checks;
  int n_pass;

  stopwatch_timer #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .toggle    (toggle),
    .disp_time (disp_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_toggle();
    toggle = 1'b1;
    clks(3);
    toggle = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    toggle   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      clks(1);
      check("reset_hold", disp_time, 24'h000000);
    end
    reset = 1'b1;
    clks(10);
    check("idle_after_release", disp_time, 24'h000000);

    pulse_toggle();
    clks(40);
    check("run_40clk", disp_time, 24'h000010);

    // Pause lands with the prescaler three counts into the period.
    pulse_toggle();
    check("paused", disp_time, 24'h000010);
    clks(50);
    check("paused_hold", disp_time, 24'h000010);

    pulse_toggle();
    clks(1);
    check("resume_partial", disp_time, 24'h000011);
    clks(3);
    check("resume_mid", disp_time, 24'h000011);
    clks(1);
    check("resume_full", disp_time, 24'h000012);

    clks(4 * 88);
    check("cc_carry", disp_time, 24'h000100);
    clks(4 * 5900);
    check("minute_carry", disp_time, 24'h010000);
    clks(4 * 99);
    check("run_99", disp_time, 24'h010099);
    clks(4);
    check("run_100", disp_time, 24'h010100);

    // Rise coincides with a tick: the count applies, then run drops.
    clks(1);
    pulse_toggle();
    check("rise_on_tick", disp_time, 24'h010101);
    clks(20);
    check("rise_on_tick_hold", disp_time, 24'h010101);
    pulse_toggle();
    clks(4);
    check("resume_after_tick", disp_time, 24'h010102);

    pulse_toggle();
    force dut.time_q = 24'h595999;
    clks(1);
    release dut.time_q;
    clks(1);
    check("preload", disp_time, 24'h595999);
    pulse_toggle();
    clks(1);
    check("full_wrap", disp_time, 24'h000000);
    clks(4);
    check("after_wrap", disp_time, 24'h000001);

    clks(2);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", disp_time, 24'h000000);
    clks(2);
    reset = 1'b1;
    clks(20);
    check("reset_stays_idle", disp_time, 24'h000000);
    pulse_toggle();
    clks(4);
    check("restart_after_reset", disp_time, 24'h000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
